// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM pipeline register and a word-addressed data RAM, performs
// sw/lw, and presents results to write-back. RAM read data is combinational
// from the latched address so it can feed lw->sw store-data forwarding in EX.
// Optional feature: define MEM_ALIGN_CHECK_EN to add mem_addressException and
// suppress RAM/register writes of misaligned lw/sw.
module mem_stage #(
  parameter int ADDR_WIDTH      = 10,
  parameter bit RESET_CLEAR_RAM = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [31:0]       ex_aluOutput,
  input  logic [31:0]       ex_writeDataToDataRAM,
  input  logic              ex_overflow,
  input  logic              ex_memWrite,
  input  logic              ex_memOutOrAluOutWriteBackToRegFile,
  input  logic              ex_writeRegEnable,
  input  logic [4:0]        ex_destReg,
  output logic              mem_valid,
  output logic [31:0]       mem_aluOutput,
  output logic [31:0]       mem_memoryData,
  output logic              mem_memOutOrAluOutWriteBackToRegFile,
  output logic              mem_writeRegEnable,
  output logic [4:0]        mem_destReg,
  output logic              mem_overflowException
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              mem_addressException
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  vld_p1;
  logic                  mem_write_p1;   // raw sw flag; overflow cancel applied via ovf_p1
  logic                  lw_p1;
  logic                  reg_we_p1;      // already cleared by overflow cancellation
  logic                  ovf_p1;
  logic                  write_done_p1;  // this sw already wrote RAM during a stall
  logic [31:0]           alu_p1;
  logic [31:0]           store_p1;
  logic [4:0]            dest_p1;

  logic [31:0]           ram [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  addr_fault;
  logic                  ram_we;
  logic                  cancel_in;

  assign cancel_in = ex_valid && ex_overflow;
  assign word_idx  = alu_p1[ADDR_WIDTH+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_fault           = vld_p1 && (mem_write_p1 || lw_p1) && (alu_p1[1:0] != 2'b00);
  assign mem_addressException = addr_fault;
`else
  assign addr_fault = 1'b0;
`endif

  // A sw writes exactly once: only while valid, not cancelled, not misaligned,
  // and not already written earlier in a stall. Reset suppresses the write.
  assign ram_we = !rst && vld_p1 && mem_write_p1 && !ovf_p1 && !write_done_p1 && !addr_fault;

  // ---- EX -> MEM boundary ----
  // EX/MEM register: priority rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      mem_write_p1  <= 1'b0;
      lw_p1         <= 1'b0;
      reg_we_p1     <= 1'b0;
      ovf_p1        <= 1'b0;
      write_done_p1 <= 1'b0;
      alu_p1        <= '0;
      store_p1      <= '0;
      dest_p1       <= '0;
    end else if (flush) begin
      vld_p1        <= 1'b0;
      mem_write_p1  <= 1'b0;
      lw_p1         <= 1'b0;
      reg_we_p1     <= 1'b0;
      ovf_p1        <= 1'b0;
      write_done_p1 <= 1'b0;
      alu_p1        <= '0;
      store_p1      <= '0;
      dest_p1       <= '0;
    end else if (stall) begin
      write_done_p1 <= write_done_p1 || ram_we;
    end else begin
      vld_p1        <= ex_valid;
      mem_write_p1  <= ex_memWrite;
      lw_p1         <= ex_memOutOrAluOutWriteBackToRegFile;
      reg_we_p1     <= ex_writeRegEnable && !cancel_in;
      ovf_p1        <= cancel_in;
      write_done_p1 <= 1'b0;
      alu_p1        <= ex_aluOutput;
      store_p1      <= ex_writeDataToDataRAM;
      dest_p1       <= ex_destReg;
    end
  end

  generate
    if (RESET_CLEAR_RAM) begin : g_ram_clr
      // Data RAM write port, zeroed while reset is held
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (ram_we) begin
          ram[word_idx] <= store_p1;
        end
      end
    end else begin : g_ram_keep
      // Data RAM write port, contents survive reset
      always_ff @(posedge clk) begin
        if (ram_we) ram[word_idx] <= store_p1;
      end
    end
  endgenerate

  assign mem_valid                            = vld_p1;
  assign mem_aluOutput                        = alu_p1;
  assign mem_memoryData                       = ram[word_idx];
  assign mem_memOutOrAluOutWriteBackToRegFile = lw_p1;
  assign mem_writeRegEnable                   = reg_we_p1 && !addr_fault;
  assign mem_destReg                          = dest_p1;
  assign mem_overflowException                = ovf_p1;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage plus hand-written
// sequences for reset, stall hold, flush-over-stall and address alignment.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid, ex_overflow, ex_memWrite, ex_lw, ex_we;
  logic [31:0] ex_alu, ex_wdata;
  logic [4:0]  ex_dest;
  logic        mem_valid, mem_lw, mem_we, mem_ovf;
  logic [31:0] mem_alu, mem_data;
  logic [4:0]  mem_dest;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_aexc;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  mem_stage dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .stall                               (stall),
    .flush                               (flush),
    .ex_valid                            (ex_valid),
    .ex_aluOutput                        (ex_alu),
    .ex_writeDataToDataRAM               (ex_wdata),
    .ex_overflow                         (ex_overflow),
    .ex_memWrite                         (ex_memWrite),
    .ex_memOutOrAluOutWriteBackToRegFile (ex_lw),
    .ex_writeRegEnable                   (ex_we),
    .ex_destReg                          (ex_dest),
    .mem_valid                           (mem_valid),
    .mem_aluOutput                       (mem_alu),
    .mem_memoryData                      (mem_data),
    .mem_memOutOrAluOutWriteBackToRegFile(mem_lw),
    .mem_writeRegEnable                  (mem_we),
    .mem_destReg                         (mem_dest),
    .mem_overflowException               (mem_ovf)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_addressException                (mem_aexc)
`endif
  );

  always #5 clk = ~clk;

  // Pending RAM writes are visible at the negedge before the edge that commits them
  always @(negedge clk) if (dut.ram_we) wr_cnt++;

  typedef struct {
    logic        v;  logic [31:0] a;  logic [31:0] d;
    logic        ov; logic mw; logic lw; logic we; logic [4:0] dst;
    logic        ev; logic [31:0] ea; logic elw; logic ewe; logic [4:0] edst;
    logic        eov; logic cd; logic [31:0] edata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  vec_t sbq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic ov, input logic mw, input logic lw, input logic we,
                       input logic [4:0] dst);
    ex_valid = v; ex_alu = a; ex_wdata = d; ex_overflow = ov;
    ex_memWrite = mw; ex_lw = lw; ex_we = we; ex_dest = dst;
  endtask

  task automatic check_ctrl_zero(input string tag);
    chk({tag, ".valid"}, 32'(mem_valid), 32'd0);
    chk({tag, ".lw"},    32'(mem_lw),    32'd0);
    chk({tag, ".we"},    32'(mem_we),    32'd0);
    chk({tag, ".ovf"},   32'(mem_ovf),   32'd0);
    chk({tag, ".alu"},   mem_alu,        32'd0);
    chk({tag, ".dest"},  32'(mem_dest),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   c0;
    //             v  a             d             ov mw lw we dst  ev ea            elw ewe edst eov cd edata
    vecs[0]  = '{1, 32'h10,   32'hDEADBEEF, 0, 1, 0, 0, 0,  1, 32'h10,   0, 0, 0,  0, 0, 32'h0};
    vecs[1]  = '{1, 32'h10,   32'h0,        0, 0, 1, 1, 3,  1, 32'h10,   1, 1, 3,  0, 1, 32'hDEADBEEF};
    vecs[2]  = '{1, 32'h55,   32'h0,        1, 0, 0, 1, 8,  1, 32'h55,   0, 0, 8,  1, 0, 32'h0};
    vecs[3]  = '{1, 32'h10,   32'h0,        0, 0, 1, 1, 3,  1, 32'h10,   1, 1, 3,  0, 1, 32'hDEADBEEF};
    vecs[4]  = '{1, 32'h10,   32'h11111111, 1, 1, 0, 0, 0,  1, 32'h10,   0, 0, 0,  1, 1, 32'hDEADBEEF};
    vecs[5]  = '{1, 32'h10,   32'h0,        0, 0, 1, 1, 3,  1, 32'h10,   1, 1, 3,  0, 1, 32'hDEADBEEF};
    vecs[6]  = '{1, 32'h1004, 32'hCAFEF00D, 0, 1, 0, 0, 0,  1, 32'h1004, 0, 0, 0,  0, 0, 32'h0};
    vecs[7]  = '{1, 32'h4,    32'h0,        0, 0, 1, 1, 2,  1, 32'h4,    1, 1, 2,  0, 1, 32'hCAFEF00D};
    vecs[8]  = '{0, 32'h4,    32'h00000BAD, 0, 1, 0, 0, 0,  0, 32'h4,    0, 0, 0,  0, 1, 32'hCAFEF00D};
    vecs[9]  = '{1, 32'h4,    32'h0,        0, 0, 1, 1, 2,  1, 32'h4,    1, 1, 2,  0, 1, 32'hCAFEF00D};
    vecs[10] = '{1, 32'h40,   32'h12345678, 0, 1, 0, 0, 0,  1, 32'h40,   0, 0, 0,  0, 0, 32'h0};
    vecs[11] = '{1, 32'h40,   32'h0,        0, 0, 1, 1, 9,  1, 32'h40,   1, 1, 9,  0, 1, 32'h12345678};
    vecs[12] = '{1, 32'h44,   32'h0,        0, 1, 0, 0, 0,  1, 32'h44,   0, 0, 0,  0, 0, 32'h0};

    // Reset for two cycles with a live sw presented: nothing may be latched
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1, 32'h10, 32'hDEADBEEF, 1, 1, 1, 1, 5'd7);
    repeat (2) @(posedge clk);
    #1 check_ctrl_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Table vectors: expectations queued at drive, popped one cycle later
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i < NV) drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].ov,
                        vecs[i].mw, vecs[i].lw, vecs[i].we, vecs[i].dst);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk($sformatf("v%0d.valid", i - 1), 32'(mem_valid), 32'(e.ev));
        chk($sformatf("v%0d.alu",   i - 1), mem_alu,         e.ea);
        chk($sformatf("v%0d.lw",    i - 1), 32'(mem_lw),     32'(e.elw));
        chk($sformatf("v%0d.we",    i - 1), 32'(mem_we),     32'(e.ewe));
        chk($sformatf("v%0d.dest",  i - 1), 32'(mem_dest),   32'(e.edst));
        chk($sformatf("v%0d.ovf",   i - 1), 32'(mem_ovf),    32'(e.eov));
        if (e.cd) chk($sformatf("v%0d.data", i - 1), mem_data, e.edata);
      end
      if (i < NV) sbq.push_back(vecs[i]);
    end

    // Stall hold: sw 0x20 enters MEM, then three stalled cycles with EX churning
    @(negedge clk);
    drive(1, 32'h20, 32'h1, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1 c0 = wr_cnt;
    chk("stall.load.valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    stall = 1'b1;
    drive(1, 32'h80, 32'h99, 1, 0, 1, 1, 5'd7);
    @(posedge clk);
    #1 chk("stall1.alu", mem_alu, 32'h20);
    chk("stall1.data", mem_data, 32'h1);
    @(negedge clk);
    dut.ram[8] <= 32'hA5A5A5A5;
    drive(1, 32'h84, 32'h98, 0, 1, 0, 1, 5'd6);
    @(posedge clk);
    #1 chk("stall2.alu", mem_alu, 32'h20);
    chk("stall2.lw", 32'(mem_lw), 32'd0);
    chk("stall2.data", mem_data, 32'hA5A5A5A5);
    @(negedge clk);
    drive(0, 32'h88, 32'h97, 0, 0, 1, 1, 5'd5);
    @(posedge clk);
    #1 chk("stall3.valid", 32'(mem_valid), 32'd1);
    chk("stall3.ovf", 32'(mem_ovf), 32'd0);
    chk("stall3.data", mem_data, 32'hA5A5A5A5);
    @(negedge clk);
    stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk("stall.writes", 32'(wr_cnt - c0), 32'd1);

    // Flush wins over stall with a valid lw waiting in EX
    @(negedge clk);
    drive(1, 32'h40, 32'h0, 0, 0, 1, 1, 5'd5);
    @(posedge clk);
    #1 chk("pre_flush.lw", 32'(mem_lw), 32'd1);
    @(negedge clk);
    flush = 1'b1; stall = 1'b1;
    @(posedge clk);
    #1 check_ctrl_zero("flush");
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Misaligned sw to 0x22, then read word 8 back through lw 0x20
    @(negedge clk);
    drive(1, 32'h22, 32'h77, 0, 1, 0, 0, 0);
    @(posedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("align.sw.aexc", 32'(mem_aexc), 32'd1);
`else
    #1 chk("align.sw.valid", 32'(mem_valid), 32'd1);
`endif
    @(negedge clk);
    drive(1, 32'h20, 32'h0, 0, 0, 1, 1, 5'd4);
    @(posedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("align.word8", mem_data, 32'hA5A5A5A5);
    chk("align.lw.aexc", 32'(mem_aexc), 32'd0);
`else
    #1 chk("align.word8", mem_data, 32'h77);
`endif
    chk("align.lw.we", 32'(mem_we), 32'd1);
    @(negedge clk);
    drive(1, 32'h23, 32'h0, 0, 0, 1, 1, 5'd4);
    @(posedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("misalign.lw.we", 32'(mem_we), 32'd0);
    chk("misalign.lw.aexc", 32'(mem_aexc), 32'd1);
`else
    #1 chk("misalign.lw.we", 32'(mem_we), 32'd1);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Contains the EX/MEM pipeline register and a word-addressed data RAM.
- Consumes the execute stage's ALU result, store data and overflow flag. Performs sw/lw. Hands results to write-back.
- Drives mem_memoryData and mem_memOutOrAluOutWriteBackToRegFile back to the execute stage for lw→sw store-data forwarding.

Parameters:
- ADDR_WIDTH, 10, word-address bits of data RAM (1024 words, byte addresses 0x000–0xFFF).
- RESET_CLEAR_RAM, 0, 1 = RAM contents zeroed while rst is high; 0 = RAM contents untouched by reset.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold EX/MEM register contents.
- flush  input  1  replace incoming instruction with a bubble.
- ex_valid  input  1  EX holds a real instruction.
- ex_aluOutput  input  32  ALU result / byte address.
- ex_writeDataToDataRAM  input  32  store data, already forwarded.
- ex_overflow  input  1  arithmetic overflow from ALU.
- ex_memWrite  input  1  instruction is sw.
- ex_memOutOrAluOutWriteBackToRegFile  input  1  instruction is lw.
- ex_writeRegEnable  input  1  instruction writes register file.
- ex_destReg  input  5  destination register number.
- mem_valid  output  1  MEM holds a real instruction.
- mem_aluOutput  output  32  latched ALU result.
- mem_memoryData  output  32  RAM read data at mem_aluOutput; combinational.
- mem_memOutOrAluOutWriteBackToRegFile  output  1  latched lw flag.
- mem_writeRegEnable  output  1  latched register-write enable, after cancellation.
- mem_destReg  output  5  latched destination register.
- mem_overflowException  output  1  to CP0; instruction in MEM overflowed.

Behaviour:
- Update priority at each rising clk: rst > flush > stall > load.
- rst:
  - mem_valid, mem_writeRegEnable, mem_memOutOrAluOutWriteBackToRegFile and mem_overflowException = 0.
  - mem_aluOutput = 0 and mem_destReg = 0.
  - Internal write-done flag = 0.
  - RAM contents per RESET_CLEAR_RAM.
- flush: load a bubble. Every control bit is 0; data fields are don't-care but must be driven 0.
- stall: all EX/MEM fields hold their values.
- load: latch all ex_* fields. mem_valid = ex_valid.
- Overflow cancellation on load, when ex_valid && ex_overflow:
  - latched writeRegEnable = 0 and latched memWrite = 0;
  - mem_overflowException = 1 while that instruction occupies MEM.
- Latency: one cycle from EX inputs to mem_* outputs.
- RAM write: at the rising edge ending the MEM cycle, when mem_valid && latched memWrite && !writeDone.
  - Word index = mem_aluOutput[ADDR_WIDTH+1:2]. Data = latched store data.
  - Address bits [1:0] are ignored when the optional feature is absent.
- writeDone flag:
  - Set by a RAM write while stall=1. Cleared on any load, flush or rst.
  - Guarantees exactly one RAM write per sw, even across multi-cycle stalls.
- RAM read: combinational from mem_aluOutput.
  - A read of the word written at the current edge returns the new data from the next cycle on.
- Address wrap: bits above ADDR_WIDTH+1 are ignored. Address 0x1004 aliases word 1.
- Bubble or cancelled instruction: never writes RAM or register file. mem_memoryData is still driven.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - Extra output mem_addressException (1 bit).
  - Set when a valid lw or sw has mem_aluOutput[1:0] != 0.
  - That instruction's RAM write and register write are suppressed.
  - If overflow is also set, both exceptions assert.
- When not defined: no extra port. Low address bits are silently ignored.

Test Plan:
- Reset then sw: rst 2 cycles, then sw with addr 0x10, data 0xDEADBEEF, ex_valid=1 → next cycle mem_valid=1, RAM word 4 = 0xDEADBEEF after following edge; a later lw at 0x10 returns 0xDEADBEEF on mem_memoryData.
- Overflow cancel: add with ex_overflow=1, ex_writeRegEnable=1, destReg=8 → mem_writeRegEnable=0, mem_overflowException=1 for exactly one cycle; an sw with ex_overflow=1 leaves RAM unchanged.
- Stall hold: sw addr 0x20 data 0x1 enters MEM, stall=1 for 3 cycles while the EX inputs change → outputs frozen, exactly one RAM write. Check with a bench write counter and by overwriting the RAM word via backdoor mid-stall: the value must not be restored.
- Flush vs stall: flush=1 and stall=1 together with a valid lw in EX → mem_valid=0 and all control outputs 0 next cycle.
- Forwarding path: lw addr 0x40 (RAM=0x12345678) in MEM, sw in EX → mem_memOutOrAluOutWriteBackToRegFile=1 and mem_memoryData=0x12345678 in the same cycle.
- Alignment (MEM_ALIGN_CHECK_EN): sw addr 0x22 → mem_addressException=1, RAM word 8 unchanged. Without the macro, same stimulus writes word 8.
